// File: rtl/sprite_jump_renderer.sv
// Single-sprite VGA pixel renderer with a frame-synchronous jump state machine.
// Optional horizontal flip when SPRITE_MIRROR_EN is defined.
module sprite_jump_renderer #(
  parameter int          W         = 20,
  parameter int          H         = 16,
  parameter int          X_POS     = 300,
  parameter int          GROUND_Y  = 200,
  parameter int          JUMP_H    = 64,
  parameter int          JUMP_STEP = 4,
  parameter logic [11:0] FG_RGB    = 12'hF00,
  parameter logic [11:0] BG_RGB    = 12'h0FF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [10:0]  hcount,
  input  logic [10:0]  vcount,
  input  logic         blank,
  input  logic         frame_tick,
  input  logic         jump,
  input  logic         bmp_we,
  input  logic [5:0]   bmp_addr,
  input  logic [W-1:0] bmp_data,
  input  logic         mirror,
  output logic [3:0]   R,
  output logic [3:0]   G,
  output logic [3:0]   B,
  output logic         sprite_on,
  output logic         airborne
);

  localparam int ROW_W = (H > 1) ? $clog2(H) : 1;
  localparam int IDX_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [11:0]      X12    = 12'(X_POS);
  localparam logic [10:0]      GND_Y  = 11'(GROUND_Y);
  localparam logic [10:0]      TOP_Y  = 11'(GROUND_Y - JUMP_H);
  localparam logic [11:0]      STEP12 = 12'(JUMP_STEP);
  localparam logic [IDX_W-1:0] W_M1   = IDX_W'(W - 1);

  typedef enum logic [1:0] {GROUND, RISE, FALL} state_t;

  state_t      state_reg, state_next;
  logic [10:0] y_reg, y_next;
  logic        jump_pend_reg, jump_pend_next;

  // Jump FSM: state and y only move on frame_tick so a frame never tears.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= GROUND;
      y_reg         <= GND_Y;
      jump_pend_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      y_reg         <= y_next;
      jump_pend_reg <= jump_pend_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    y_next         = y_reg;
    jump_pend_next = jump_pend_reg | jump;
    if (frame_tick) begin
      jump_pend_next = 1'b0;
      case (state_reg)
        GROUND: begin
          y_next = GND_Y;
          if (jump_pend_reg || jump) state_next = RISE;
        end
        RISE: begin
          // y - STEP <= TOP rewritten as y <= TOP + STEP to avoid underflow
          if ({1'b0, y_reg} <= ({1'b0, TOP_Y} + STEP12)) begin
            y_next     = TOP_Y;
            state_next = FALL;
          end else begin
            y_next = y_reg - 11'(JUMP_STEP);
          end
        end
        FALL: begin
          if (({1'b0, y_reg} + STEP12) >= {1'b0, GND_Y}) begin
            y_next     = GND_Y;
            state_next = GROUND;
          end else begin
            y_next = y_reg + 11'(JUMP_STEP);
          end
        end
        default: begin
          state_next = GROUND;
          y_next     = GND_Y;
        end
      endcase
    end
  end

  assign airborne = (state_reg != GROUND);

  logic mirror_sel;
`ifdef SPRITE_MIRROR_EN
  logic mirror_reg;
  always_ff @(posedge clk) begin
    if (!rst_n)          mirror_reg <= 1'b0;
    else if (frame_tick) mirror_reg <= mirror;
  end
  assign mirror_sel = mirror_reg;
`else
  logic unused_mirror;
  assign unused_mirror = mirror;
  assign mirror_sel    = 1'b0;
`endif

  // Bitmap rows: plain registers, not cleared by reset.
  logic [W-1:0] bmp_mem [H];
  always_ff @(posedge clk) begin
    if (bmp_we && ({1'b0, bmp_addr} < 7'(H)))
      bmp_mem[bmp_addr[ROW_W-1:0]] <= bmp_data;
  end

  // Stage 1: hit test, bit index and registered row read.
  logic [11:0]      dx, dy;
  logic             hit;
  logic [IDX_W-1:0] idx;
  logic [ROW_W-1:0] rd_row;

  assign dx     = {1'b0, hcount} - X12;
  assign dy     = {1'b0, vcount} - {1'b0, y_reg};
  assign hit    = (dx < 12'(W)) && (dy < 12'(H));
  assign rd_row = hit ? dy[ROW_W-1:0] : '0;
  assign idx    = !hit      ? '0 :
                  mirror_sel ? dx[IDX_W-1:0] : (W_M1 - dx[IDX_W-1:0]);

  logic [W-1:0]     row_reg;
  logic             hit_reg, blank_reg;
  logic [IDX_W-1:0] idx_reg;

  always_ff @(posedge clk) begin
    row_reg <= bmp_mem[rd_row];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_reg   <= 1'b0;
      idx_reg   <= '0;
      blank_reg <= 1'b1;
    end else begin
      hit_reg   <= hit;
      idx_reg   <= idx;
      blank_reg <= blank;
    end
  end

  // Stage 2: colour select and output registers.
  logic        pix;
  logic [11:0] rgb_reg;
  logic        sprite_on_reg;

  assign pix = hit_reg & row_reg[idx_reg];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb_reg       <= 12'h000;
      sprite_on_reg <= 1'b0;
    end else begin
      rgb_reg       <= blank_reg ? 12'h000 : (pix ? FG_RGB : BG_RGB);
      sprite_on_reg <= pix;
    end
  end

  assign R         = rgb_reg[11:8];
  assign G         = rgb_reg[7:4];
  assign B         = rgb_reg[3:0];
  assign sprite_on = sprite_on_reg;

endmodule

// File: tb/tb_sprite_jump_renderer.sv
// Randomized self-checking bench for sprite_jump_renderer against a behavioural model.
module tb_sprite_jump_renderer;
  localparam int W = 20, H = 16, X = 300, GY = 200, JH = 64, JS = 4;
  localparam logic [11:0] FG = 12'hF00, BG = 12'h0FF;

  logic clk = 0, rst_n = 0;
  logic [10:0] hcount = 0, vcount = 0;
  logic blank = 1, frame_tick = 0, jump = 0, bmp_we = 0, mirror = 0;
  logic [5:0] bmp_addr = 0;
  logic [W-1:0] bmp_data = 0;
  logic [3:0] R, G, B;
  logic sprite_on, airborne;

  sprite_jump_renderer dut (
    .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount), .blank(blank),
    .frame_tick(frame_tick), .jump(jump), .bmp_we(bmp_we), .bmp_addr(bmp_addr),
    .bmp_data(bmp_data), .mirror(mirror), .R(R), .G(G), .B(B),
    .sprite_on(sprite_on), .airborne(airborne)
  );

  always #20 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // behavioural model: phase 0 ground, 1 rising, 2 falling
  logic [W-1:0] bmp_m [H];
  int ym = GY, ph = 0;
  bit pend_m = 0, mirror_m = 0;

  typedef struct { logic [11:0] rgb; logic on; } exp_t;
  exp_t exp_q[$];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (y=%0d)", tag, got, exp, ym);
    end
  endtask

  function automatic exp_t model_px(int h, int v, bit b);
    exp_t e;
    int dx = h - X, dy = v - ym;
    bit on = 0;
    if (dx >= 0 && dx < W && dy >= 0 && dy < H)
      on = mirror_m ? bmp_m[dy][dx] : bmp_m[dy][W-1-dx];
    e.on  = on;
    e.rgb = b ? 12'h000 : (on ? FG : BG);
    return e;
  endfunction

  task automatic step_px(int h, int v, bit b);
    exp_t e;
    hcount = 11'(h); vcount = 11'(v); blank = b;
    exp_q.push_back(model_px(h, v, b));
    @(posedge clk); #1;
    if (exp_q.size() == 2) begin
      e = exp_q.pop_front();
      chk($sformatf("rgb h=%0d v=%0d", hcount, vcount), 32'({R, G, B}), 32'(e.rgb));
      chk("sprite_on", 32'(sprite_on), 32'(e.on));
    end
  endtask

  task automatic flush();
    step_px(0, 0, 1);
    step_px(0, 0, 1);
    exp_q.delete();
  endtask

  task automatic wr(int a, logic [W-1:0] d);
    bmp_we = 1; bmp_addr = 6'(a); bmp_data = d;
    @(posedge clk); #1;
    bmp_we = 0;
    if (a < H) bmp_m[a] = d;
  endtask

  task automatic pulse_jump();
    jump = 1;
    @(posedge clk); #1;
    jump = 0;
    pend_m = 1;
  endtask

  task automatic tick(bit j);
    jump = j; frame_tick = 1; blank = 1;
    @(posedge clk); #1;
    frame_tick = 0; jump = 0;
    if (ph == 0) begin
      if (pend_m || j) ph = 1;
    end else if (ph == 1) begin
      ym = ym - JS;
      if (ym <= GY - JH) begin ym = GY - JH; ph = 2; end
    end else begin
      ym = ym + JS;
      if (ym >= GY) begin ym = GY; ph = 0; end
    end
    pend_m = 0;
`ifdef SPRITE_MIRROR_EN
    mirror_m = mirror;
`endif
    chk("airborne", 32'(airborne), 32'(ph != 0));
  endtask

  // edges of the sprite box around the current model position
  task automatic probe_y();
    step_px(X, ym - 1, 0);
    step_px(X, ym, 0);
    step_px(X + W - 1, ym + H - 1, 0);
    step_px(X + W - 1, ym + H, 0);
    flush();
  endtask

  task automatic rnd_px(int n);
    for (int i = 0; i < n; i++)
      step_px(X - 4 + int'($urandom_range(0, W + 8)), ym - 3 + int'($urandom_range(0, H + 6)),
              $urandom_range(0, 7) == 0);
    flush();
  endtask

  task automatic do_reset();
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    ym = GY; ph = 0; pend_m = 0; mirror_m = 0;
  endtask

  initial begin
    int air_cnt, guard;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rgb", 32'({R, G, B}), 32'h0);
    chk("reset_on", 32'(sprite_on), 32'h0);
    chk("reset_air", 32'(airborne), 32'h0);
    rst_n = 1;
    $display("[TB] reset checked");

    for (int r = 0; r < H; r++) wr(r, W'($urandom));

    wr(2, 20'h10038);
    for (int h = 298; h <= 322; h++) step_px(h, 202, 0);
    flush();
    $display("[TB] basic render row 2");

    wr(0, '1); wr(H - 1, '1);
    step_px(299, 200, 0); step_px(300, 200, 0); step_px(319, 200, 0); step_px(320, 200, 0);
    step_px(300, 215, 0); step_px(300, 216, 0);
    flush();
    $display("[TB] boundary columns and rows");

    step_px(300, 200, 1);
    step_px(305, 201, 1);
    flush();
    $display("[TB] blank over sprite");

    rnd_px(200);
    $display("[TB] random render at ground");

    for (int i = 0; i < 4; i++) wr(H + int'($urandom_range(0, 63 - H)), W'($urandom));
    rnd_px(100);
    $display("[TB] out-of-range writes ignored");

    wr(0, '1); wr(H - 1, '1);
    pulse_jump();
    air_cnt = 0;
    for (int t = 1; t <= 40; t++) begin
      if (t == 5) pulse_jump();
      tick(0);
      if (airborne) air_cnt++;
      probe_y();
      if (t % 8 == 3) rnd_px(24);
    end
    chk("airborne_ticks", 32'(air_cnt), 32'd32);
    $display("[TB] jump cycle, airborne ticks=%0d", air_cnt);

    tick(1);
    guard = 0;
    while (!(ph == 2 && ym == 160) && guard < 100) begin
      tick(0);
      guard++;
    end
    chk("reach_y160", 32'(ph == 2 && ym == 160), 32'd1);
    step_px(X, ym, 0);
    do_reset();
    chk("midjump_rgb", 32'({R, G, B}), 32'h0);
    chk("midjump_on", 32'(sprite_on), 32'h0);
    chk("midjump_air", 32'(airborne), 32'h0);
    exp_q.delete();
    probe_y();
    tick(0);
    probe_y();
    $display("[TB] reset mid-jump");

    pulse_jump();
    do_reset();
    tick(0);
    probe_y();
    $display("[TB] reset clears pending jump");

`ifdef SPRITE_MIRROR_EN
    wr(0, 20'h80000);
    mirror = 1;
    tick(0);
    step_px(319, 200, 0); step_px(300, 200, 0);
    flush();
    rnd_px(100);
    mirror = 0;
    tick(0);
    rnd_px(60);
    $display("[TB] mirror");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
